i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//   Single-address I2C target (responder) for the on-board control bus. It is the bus end
//   answering the team's i2c initiator.
//   Oversamples SCL/SDA on clk, detects START/STOP, matches a 7-bit address, ACKs it,
//   then either delivers written bytes to fabric or shifts out fabric-supplied bytes.
//   Open-drain only: pulls SDA low or releases it; never drives SCL (no clock stretching).
// PARAMETERS
//   DEV_ADDR     7'h39  7-bit address this target answers to
//   SYNC_STAGES  2      synchroniser flops on SCL and SDA inputs (min 2)
// PORTS
//   clk        in     1  system clock, >= 20x SCL frequency
//   rst        in     1  reset, synchronous, active-high
//   scl        inout  1  tri1 bus clock; read only, never driven
//   sda        inout  1  tri1 bus data; driven 0 or Z only
//   rx_data    out    8  last byte written by initiator, MSB first on bus
//   rx_valid   out    1  1-cycle pulse, rx_data updated this cycle
//   tx_data    in     8  byte to return on next read byte
//   tx_load    out    1  1-cycle pulse, tx_data captured this cycle
//   addressed  out    1  high from address ACK until STOP/START/NACK-abort
//   busy       out    1  high from START until STOP
// BEHAVIOUR
//   Reset: sda released (Z), rx_data=0, rx_valid=0, tx_load=0, addressed=0, busy=0, state IDLE.
//   rst mid-transfer releases SDA on the next clk edge; bus activity is ignored until the next START.
//   Inputs: SYNC_STAGES flops, then one register for edge detection.
//     All bus events are seen SYNC_STAGES+1 clk cycles after the pin.
//   START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are valid in any state.
//     START (incl. repeated) -> ADDR, bit counter=0. STOP -> IDLE, SDA released.
//   SDA is sampled on the SCL rising edge. SDA output changes only on the SCL falling edge.
//   States:
//     IDLE      wait for START; busy=0.
//     ADDR      shift 8 bits (A6..A0, RW) on SCL rising edges.
//               After the 8th bit: match -> ADDR_ACK; mismatch -> IGNORE.
//     ADDR_ACK  pull SDA low from the falling edge after the 8th bit to the next falling edge.
//               Set addressed=1. RW=0 -> WR_BYTE.
//               RW=1 -> pulse tx_load on the ACK's final falling edge, then RD_BYTE.
//     WR_BYTE   shift 8 bits. On the 8th rising edge: rx_data<=byte, rx_valid pulses.
//               Then WR_ACK.
//     WR_ACK    same timing as ADDR_ACK (target always ACKs written bytes), then WR_BYTE.
//     RD_BYTE   drive the shift register MSB first. Bit 7 is on SDA (0 = pull, 1 = release)
//               from the tx_load cycle; each subsequent falling edge advances one bit.
//               SDA is released after the 8th falling edge. Then RD_ACK.
//     RD_ACK    sample the initiator's ACK on the rising edge.
//               ACK(0) -> pulse tx_load on the next falling edge, RD_BYTE.
//               NACK(1) -> IGNORE, addressed=0.
//     IGNORE    SDA released; wait for START or STOP.
//   Simultaneous events: START/STOP take precedence over any SCL-edge action in the same cycle.
//   rx_valid and tx_load never assert in the same cycle. Both are 0 in IDLE and IGNORE.
//   The bit counter is 4 bits; it resets to 0 on START and on each byte boundary (never wraps past 8).
//   An SCL edge with no preceding START is ignored.
// TESTING
//   1. Write 0x72 (addr 0x39, W), data 0xA5, 0x00, STOP -> ACK low on 3 ACK slots;
//      rx_valid pulses twice (rx_data 0xA5 then 0x00); busy falls after STOP.
//   2. Addr 0x3A (W) -> no ACK (SDA stays 1 in ACK slot); no rx_valid; addressed stays 0;
//      next transfer to 0x39 still ACKed.
//   3. Read 0x73 with tx_data 0x5C, initiator ACK, tx_data 0xFF, initiator NACK, STOP ->
//      bus reads 0x5C, 0xFF; tx_load pulses exactly twice; SDA released after NACK.
//   4. Write addr+1 byte, repeated START, read 1 byte ->
//      second START returns to ADDR; correct ACKs; addressed stays high through repeated START ACK.
//   5. rst asserted after the 4th data bit of a read byte -> SDA released next clk;
//      SCL pulses without a START get no response; the next full transaction succeeds.
//   6. STOP injected mid WR_BYTE after 3 bits -> no rx_valid; state IDLE; busy=0.

Source files
------------

// File: rtl/i2c_target.sv
// Single-address I2C target for the on-board control bus.
// Oversamples SCL/SDA on clk, answers DEV_ADDR, delivers written bytes to the
// fabric and returns fabric-supplied bytes on reads. SDA is open-drain (0 or Z),
// SCL is only observed (no clock stretching).
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | bus free, waiting for START
// ADDR     | shifting in A6..A0 + RW on SCL rising edges
// ADDR_ACK | holding SDA low for the address ACK bit
// WR_BYTE  | shifting in a data byte from the initiator
// WR_ACK   | holding SDA low for the data ACK bit
// RD_BYTE  | driving a data byte MSB first, one bit per SCL falling edge
// RD_ACK   | SDA released, sampling the initiator's ACK/NACK
// IGNORE   | not addressed or NACKed; SDA released until START/STOP
module i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       addressed,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_BYTE  = 3'd3,
        WR_ACK   = 3'd4,
        RD_BYTE  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [6:0]             tx_sh;
    logic                   sda_oe;
    logic                   addr_match, rw_bit;

    // Synchroniser chains plus one edge-detect register; free-running so that
    // a reset never fabricates a bus edge against the live pin level.
    always_ff @(posedge clk) begin
        scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
        sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        scl_d    <= scl_sync[SYNC_STAGES-1];
        sda_d    <= sda_sync[SYNC_STAGES-1];
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_det  = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det   = scl_s & scl_d & ~sda_d & sda_s;
    assign addr_match = (shreg[7:1] == DEV_ADDR);
    assign rw_bit     = shreg[0];

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; START/STOP override any SCL-edge action in the same cycle
    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:     if (scl_fall && bit_cnt == 4'd8) state_nxt = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall) state_nxt = rw_bit ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (scl_fall && bit_cnt == 4'd8) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall) state_nxt = WR_BYTE;
                RD_BYTE:  if (scl_fall && bit_cnt == 4'd7) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s)                  state_nxt = IGNORE;
                    else if (scl_fall && bit_cnt == 4'd1)   state_nxt = RD_BYTE;
                end
                default:  state_nxt = state;
            endcase
        end
    end

    // Datapath: shifting, bit counting, SDA pull and fabric strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 4'd0;
            shreg     <= 8'd0;
            tx_sh     <= 7'd0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            addressed <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            if (start_det || stop_det) begin
                bit_cnt   <= 4'd0;
                sda_oe    <= 1'b0;
                addressed <= 1'b0;
            end else begin
                case (state)
                    ADDR, WR_BYTE: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == WR_BYTE && bit_cnt == 4'd7) begin
                                rx_data  <= {shreg[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state == WR_BYTE || addr_match) sda_oe <= 1'b1;
                            if (state == ADDR && addr_match)    addressed <= 1'b1;
                        end
                    end
                    ADDR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (state == ADDR_ACK && rw_bit) begin
                                tx_sh   <= tx_data[6:0];
                                sda_oe  <= ~tx_data[7];
                                tx_load <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                sda_oe  <= ~tx_sh[6];
                                tx_sh   <= {tx_sh[5:0], 1'b1};
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) addressed <= 1'b0;
                            else       bit_cnt   <= 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            bit_cnt <= 4'd0;
                            tx_sh   <= tx_data[6:0];
                            sda_oe  <= ~tx_data[7];
                            tx_load <= 1'b1;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // Output decode from state
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed + randomized bench for i2c_target acting as the bus initiator.
module tb_i2c_target;

    localparam int         Q   = 10;
    localparam logic [6:0] DEV = 7'h39;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl_low = 1'b0;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        scl, sda;
    logic [7:0] rx_data;
    logic       rx_valid, tx_load, addressed, busy;

    pullup (scl);
    pullup (sda);
    assign scl = m_scl_low ? 1'b0 : 1'bz;
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_load(tx_load), .addressed(addressed), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_err = 0;
    int         rxv_cnt = 0, txl_cnt = 0, both_cnt = 0;
    int         exp_rxv = 0, exp_txl = 0;
    logic [7:0] rx_seen[$];
    logic [7:0] exp_rx[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_seen.push_back(rx_data);
        end
        if (tx_load) txl_cnt++;
        if (rx_valid && tx_load) both_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Works from idle (SCL/SDA high) and as a repeated START (SCL low).
    task automatic bus_start();
        m_sda_low = 1'b0; wait_clk(Q);
        m_scl_low = 1'b0; wait_clk(Q);
        m_sda_low = 1'b1; wait_clk(Q);
        m_scl_low = 1'b1; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_clk(Q);
        m_scl_low = 1'b0; wait_clk(Q);
        m_sda_low = 1'b0; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;   wait_clk(Q);
        m_scl_low = 1'b0; wait_clk(2*Q);
        m_scl_low = 1'b1; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, output logic adr);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda_low = 1'b0; wait_clk(Q);
        m_scl_low = 1'b0; wait_clk(Q);
        ack = sda;
        adr = addressed;
        wait_clk(Q);
        m_scl_low = 1'b1; wait_clk(Q);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q);
            m_scl_low = 1'b0; wait_clk(Q);
            d[i] = sda;
            wait_clk(Q);
            m_scl_low = 1'b1;
        end
        wait_clk(Q);
        m_sda_low = ~nack; wait_clk(Q);
        m_scl_low = 1'b0;  wait_clk(2*Q);
        m_scl_low = 1'b1;  wait_clk(Q);
        m_sda_low = 1'b0;
    endtask

    logic       ack, adr, exp_ack, rw;
    logic [7:0] rd, d;
    logic [6:0] addr;
    logic [7:0] rbytes[4];
    int         nb, ghost;

    initial begin
        // reset state
        wait_clk(4);
        chk("rst_sda", sda, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_addressed", addressed, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        wait_clk(Q);

        // 1: write A5, 00 to our address
        bus_start();
        chk("t1_busy_start", busy, 1);
        send_byte({DEV, 1'b0}, ack, adr);
        chk("t1_addr_ack", ack, 0);
        chk("t1_addressed", adr, 1);
        send_byte(8'hA5, ack, adr);  chk("t1_d0_ack", ack, 0);
        send_byte(8'h00, ack, adr);  chk("t1_d1_ack", ack, 0);
        exp_rx.push_back(8'hA5); exp_rx.push_back(8'h00); exp_rxv += 2;
        bus_stop();
        wait_clk(Q);
        chk("t1_busy_stop", busy, 0);
        chk("t1_rxv_cnt", rxv_cnt, exp_rxv);

        // 2: wrong address is not acknowledged
        bus_start();
        send_byte(8'h74, ack, adr);
        chk("t2_nack", ack, 1);
        chk("t2_addressed", adr, 0);
        bus_stop(); wait_clk(Q);
        chk("t2_rxv_cnt", rxv_cnt, exp_rxv);
        bus_start();
        send_byte({DEV, 1'b0}, ack, adr);
        chk("t2_next_ack", ack, 0);
        bus_stop(); wait_clk(Q);

        // 3: read 5C (ACK), FF (NACK)
        tx_data = 8'h5C;
        bus_start();
        send_byte({DEV, 1'b1}, ack, adr);
        chk("t3_addr_ack", ack, 0);
        tx_data = 8'hFF;
        recv_byte(1'b0, rd); chk("t3_byte0", rd, 8'h5C);
        recv_byte(1'b1, rd); chk("t3_byte1", rd, 8'hFF);
        exp_txl += 2;
        wait_clk(Q);
        chk("t3_sda_released", sda, 1);
        chk("t3_addressed_nack", addressed, 0);
        bus_stop(); wait_clk(Q);
        chk("t3_txl_cnt", txl_cnt, exp_txl);

        // 4: write, repeated START, read
        d = 8'($urandom);
        bus_start();
        send_byte({DEV, 1'b0}, ack, adr); chk("t4_waddr_ack", ack, 0);
        send_byte(d, ack, adr);           chk("t4_wdata_ack", ack, 0);
        exp_rx.push_back(d); exp_rxv++;
        tx_data = 8'($urandom);
        rbytes[0] = tx_data;
        bus_start();
        chk("t4_busy_rs", busy, 1);
        send_byte({DEV, 1'b1}, ack, adr);
        chk("t4_raddr_ack", ack, 0);
        chk("t4_addressed_rs", adr, 1);
        recv_byte(1'b1, rd); chk("t4_rbyte", rd, rbytes[0]);
        exp_txl++;
        bus_stop(); wait_clk(Q);

        // 5: reset in the middle of a read byte
        tx_data = 8'hA0;
        bus_start();
        send_byte({DEV, 1'b1}, ack, adr); chk("t5_addr_ack", ack, 0);
        exp_txl++;
        for (int i = 0; i < 4; i++) begin
            wait_clk(Q);
            m_scl_low = 1'b0; wait_clk(2*Q);
            m_scl_low = 1'b1;
        end
        wait_clk(Q);
        chk("t5_bit3_driven", sda, 0);
        rst = 1'b1;
        wait_clk(1);
        chk("t5_rst_release", sda, 1);
        wait_clk(2);
        rst = 1'b0;
        chk("t5_busy_rst", busy, 0);
        ghost = 0;
        for (int i = 0; i < 6; i++) begin
            wait_clk(Q);
            m_scl_low = 1'b0; wait_clk(Q);
            if (sda !== 1'b1 || addressed !== 1'b0) ghost++;
            wait_clk(Q);
            m_scl_low = 1'b1;
        end
        wait_clk(Q);
        m_scl_low = 1'b0; wait_clk(Q);
        chk("t5_no_response", ghost, 0);
        chk("t5_busy_idle", busy, 0);
        d = 8'($urandom);
        bus_start();
        send_byte({DEV, 1'b0}, ack, adr); chk("t5_recover_ack", ack, 0);
        send_byte(d, ack, adr);           chk("t5_recover_data", ack, 0);
        exp_rx.push_back(d); exp_rxv++;
        bus_stop(); wait_clk(Q);

        // 6: STOP after 3 bits of a write byte
        bus_start();
        send_byte({DEV, 1'b0}, ack, adr); chk("t6_addr_ack", ack, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus_stop(); wait_clk(Q);
        chk("t6_busy", busy, 0);
        chk("t6_addressed", addressed, 0);
        chk("t6_rxv_cnt", rxv_cnt, exp_rxv);

        // randomized transactions against the reference model
        for (int t = 0; t < 8; t++) begin
            addr = ($urandom_range(0, 1) == 1) ? DEV : 7'($urandom);
            rw   = 1'($urandom_range(0, 1));
            nb   = $urandom_range(1, 3);
            exp_ack = (addr == DEV);
            for (int k = 0; k < 4; k++) rbytes[k] = 8'($urandom);
            tx_data = rbytes[0];
            bus_start();
            send_byte({addr, rw}, ack, adr);
            chk("rnd_addr_ack", ack, exp_ack ? 0 : 1);
            chk("rnd_addressed", adr, exp_ack ? 1 : 0);
            if (exp_ack && !rw) begin
                for (int k = 0; k < nb; k++) begin
                    send_byte(rbytes[k], ack, adr);
                    chk("rnd_wdata_ack", ack, 0);
                    exp_rx.push_back(rbytes[k]); exp_rxv++;
                end
            end else if (exp_ack && rw) begin
                for (int k = 0; k < nb; k++) begin
                    tx_data = rbytes[k+1];
                    recv_byte(k == nb - 1, rd);
                    chk("rnd_rdata", rd, rbytes[k]);
                end
                exp_txl += nb;
            end
            bus_stop(); wait_clk(Q);
            chk("rnd_busy_stop", busy, 0);
        end

        // totals
        chk("tot_rxv_cnt", rxv_cnt, exp_rxv);
        chk("tot_txl_cnt", txl_cnt, exp_txl);
        chk("tot_rx_vs_tx_overlap", both_cnt, 0);
        chk("tot_rx_queue_len", rx_seen.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size(); i++) begin
            chk("tot_rx_byte", (i < rx_seen.size()) ? rx_seen[i] : 8'hxx, exp_rx[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
